// File: rtl/bsr_if.sv
// rtl/bsr_if.sv - sample stream and register bus bundle for the bsr receiver
//
// Purpose: groups the modulated sample input, the byte-wide register access
// port and the interrupt line into one bundle.
//   master : drives IN/IN_VALID and register accesses, observes results
//   slave  : the bsr receiver itself
// Signals:
//   IN[7:0], IN_VALID       - received modulated sample stream
//   addr[7:0], Data_in[7:0] - register address and write data
//   wr_en, rd_en            - one-cycle access strobes
//   Data_out[7:0], ready    - registered read data and access-complete pulse
//   BSR_INT                 - interrupt request
interface bsr_if;
  logic [7:0] IN;
  logic       IN_VALID;
  logic [7:0] Data_in;
  logic [7:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] Data_out;
  logic       ready;
  logic       BSR_INT;

  modport master (
    output IN, IN_VALID, Data_in, addr, wr_en, rd_en,
    input  Data_out, ready, BSR_INT
  );

  modport slave (
    input  IN, IN_VALID, Data_in, addr, wr_en, rd_en,
    output Data_out, ready, BSR_INT
  );
endinterface

// File: rtl/bsr.sv
// rtl/bsr.sv - gray-coded two-byte frame receiver with register access port
//
// Purpose: hunts for the SYNC sample, gray-decodes the next two valid samples
// into BSR_DATA_0/BSR_DATA_1 and raises INTFLAG. A mid-frame gap of TIMEOUT
// cycles without a valid sample, or clearing RXENABLE, drops the partial frame.
// Ports:
//   SYS_CLK - system clock, rising edge
//   RST_N   - asynchronous active-low reset
//   bus     - bsr_if.slave: sample stream, register access, BSR_INT
// Registers: 0x00 BSR_CONTROL {3'b0, OVERRUN, STATUS, INTFLAG, INTMSK, RXENABLE}
//            0x01 BSR_DATA_0 (RO), 0x02 BSR_DATA_1 (RO), others read 0.
module bsr #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 16
) (
  input  logic  SYS_CLK,
  input  logic  RST_N,
  bsr_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {HUNT, BYTE0, BYTE1} state_t;

  state_t        state;
  logic [CW-1:0] idle_cnt;
  logic [7:0]    shadow;
  logic [7:0]    data0;
  logic [7:0]    data1;
  logic          rxenable;
  logic          intmsk;
  logic          intflag;
  logic          overrun;

  logic [7:0]    decoded;
  logic [7:0]    rd_data;
  logic          wr_ctrl;
  logic          w1c_flag;
  logic          w1c_ovr;
  logic          frame_done;
  logic          idle_hit;
  logic          unused_bits;

  function automatic logic [7:0] gray_decode(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign decoded     = gray_decode(bus.IN);
  assign wr_ctrl     = bus.wr_en && (bus.addr == 8'h00);
  assign w1c_flag    = wr_ctrl && bus.Data_in[2];
  assign w1c_ovr     = wr_ctrl && bus.Data_in[4];
  assign frame_done  = rxenable && bus.IN_VALID && (state == BYTE1);
  assign idle_hit    = (idle_cnt == CW'(TIMEOUT - 1));
  assign unused_bits = ^{bus.Data_in[7:5], bus.Data_in[3]};

  assign bus.BSR_INT = intmsk & intflag;

  // Read data is taken from pre-edge state, so a same-cycle write returns
  // the value before that write.
  always_comb begin
    rd_data = 8'h00;
    case (bus.addr)
      8'h00:   rd_data = {3'b000, overrun, (state != HUNT), intflag, intmsk, rxenable};
      8'h01:   rd_data = data0;
      8'h02:   rd_data = data1;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= HUNT;
      idle_cnt     <= '0;
      shadow       <= 8'h00;
      data0        <= 8'h00;
      data1        <= 8'h00;
      rxenable     <= 1'b0;
      intmsk       <= 1'b0;
      intflag      <= 1'b0;
      overrun      <= 1'b0;
      bus.Data_out <= 8'h00;
      bus.ready    <= 1'b0;
    end else begin
      // Receive path; a disabled receiver sits in HUNT and ignores IN.
      if (!rxenable) begin
        state    <= HUNT;
        idle_cnt <= '0;
      end else if (state == HUNT) begin
        idle_cnt <= '0;
        if (bus.IN_VALID && (bus.IN == SYNC)) begin
          state <= BYTE0;
        end
      end else if (bus.IN_VALID) begin
        // SYNC inside a frame is ordinary data, no resync.
        idle_cnt <= '0;
        if (state == BYTE0) begin
          shadow <= decoded;
          state  <= BYTE1;
        end else begin
          data0 <= shadow;
          data1 <= decoded;
          state <= HUNT;
        end
      end else if (idle_hit) begin
        idle_cnt <= '0;
        state    <= HUNT;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (wr_ctrl) begin
        rxenable <= bus.Data_in[0];
        intmsk   <= bus.Data_in[1];
      end

      // Completion beats a coincident W1C; a flag cleared in the same cycle
      // does not count as still pending, so no overrun then.
      if (frame_done) begin
        intflag <= 1'b1;
      end else if (w1c_flag) begin
        intflag <= 1'b0;
      end

      if (frame_done && intflag && !w1c_flag) begin
        overrun <= 1'b1;
      end else if (w1c_ovr) begin
        overrun <= 1'b0;
      end

      bus.ready <= bus.rd_en | bus.wr_en;
      if (bus.rd_en) begin
        bus.Data_out <= rd_data;
      end
    end
  end

endmodule
